perm_box_engine: RTL and testbench

//  Parametrised, registered, programmable bit-permutation unit for the f-block datapath.

---
 rtl/perm_box_engine.sv | 186 ++++++++++++++++++
 tb/tb_perm_box_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_box_engine.sv
// -----------------------------------------------------------------------------
// perm_box_engine
//   Registered, table-driven bit permutation for the f-block datapath.
//   Each accepted word is permuted either forward (gather: out[i] = in[tbl[i]])
//   or inverse (scatter: out[j] = OR of in[i] where tbl[i] == j), chosen per
//   word by in_inv. The result is registered, so latency is one cycle. A
//   valid/ready handshake provides backpressure at full throughput.
//   The table resets to the DES straight-P table when WIDTH == 32, and to the
//   identity otherwise. It can be rewritten one entry at a time through the
//   cfg_* port. Out-of-range writes are dropped and flagged on cfg_err.
//
//   Optional feature macro: PERM_CHECK_EN
//     When defined, the output tbl_ok is added. It is high while the table is
//     a bijection. Input acceptance is blocked while tbl_ok is low.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      input word valid
//   in_ready  out  1      engine can accept a word
//   in_data   in   WIDTH  word to permute
//   in_inv    in   1      0 = forward (gather), 1 = inverse (scatter)
//   out_valid out  1      out_data valid
//   out_ready in   1      downstream accepts out_data
//   out_data  out  WIDTH  permuted word
//   cfg_we    in   1      table write strobe
//   cfg_addr  in   SEL_W  table index (output bit position)
//   cfg_data  in   SEL_W  source bit index for that position
//   cfg_err   out  1      one-cycle pulse after a rejected config write
//   xfer_cnt  out  CNT_W  completed output transfers, wrapping
//   tbl_ok    out  1      (PERM_CHECK_EN only) table is a bijection
// -----------------------------------------------------------------------------
module perm_box_engine #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0] cfg_data,
    output logic             cfg_err,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef PERM_CHECK_EN
    ,
    output logic             tbl_ok
`endif
);

    localparam logic [31:0] WIDTH_U = WIDTH;

    // Reset contents of one table entry: DES P (0-based) for 32-bit words,
    // identity for any other width.
    function automatic logic [SEL_W-1:0] default_entry(input int idx);
        int v;
        v = idx;
        if (WIDTH == 32) begin
            case (idx)
                0:  v = 15;  1:  v = 6;   2:  v = 19;  3:  v = 20;
                4:  v = 28;  5:  v = 11;  6:  v = 27;  7:  v = 16;
                8:  v = 0;   9:  v = 14;  10: v = 22;  11: v = 25;
                12: v = 4;   13: v = 17;  14: v = 30;  15: v = 9;
                16: v = 1;   17: v = 7;   18: v = 23;  19: v = 13;
                20: v = 31;  21: v = 26;  22: v = 2;   23: v = 8;
                24: v = 18;  25: v = 12;  26: v = 29;  27: v = 5;
                28: v = 21;  29: v = 10;  30: v = 3;   31: v = 24;
                default: v = idx;
            endcase
        end
        return SEL_W'(v);
    endfunction

    logic [SEL_W-1:0] r_tbl [WIDTH];
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_data_p1;
    logic             r_cfg_err;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_perm;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_in_ready;

    // Gather and scatter are both evaluated; in_inv picks one.
    always_comb begin
        w_fwd = '0;
        w_inv = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fwd[i] = in_data[r_tbl[i]];
            for (int j = 0; j < WIDTH; j++) begin
                if (r_tbl[i] == SEL_W'(j)) begin
                    w_inv[j] = w_inv[j] | in_data[i];
                end
            end
        end
    end

    assign w_perm   = in_inv ? w_inv : w_fwd;
    assign w_cfg_ok = (32'(cfg_addr) < WIDTH_U) && (32'(cfg_data) < WIDTH_U);

`ifdef PERM_CHECK_EN
    logic [WIDTH-1:0] w_hit;
    logic             r_tbl_ok;

    // With every entry in range, hitting every output position means the
    // table is onto, and therefore a bijection.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (r_tbl[i] == SEL_W'(j)) begin
                    w_hit[j] = 1'b1;
                end
            end
        end
    end

    // The table only changes on accepted writes, so tracking it every cycle
    // is the same as re-evaluating on the cycle after each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl_ok <= 1'b1;
        end else begin
            r_tbl_ok <= &w_hit;
        end
    end

    assign tbl_ok     = r_tbl_ok;
    assign w_in_ready = (!r_vld_p1 || out_ready) && r_tbl_ok;
`else
    assign w_in_ready = !r_vld_p1 || out_ready;
`endif

    assign w_accept = in_valid && w_in_ready;

    // Table: a word accepted alongside a write already sampled the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_tbl[i] <= default_entry(i);
            end
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (cfg_we && w_cfg_ok) begin
                r_tbl[cfg_addr] <= cfg_data;
            end
        end
    end

    // Stage p1: registered result plus its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_perm;
            end else if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end
            if (r_vld_p1 && out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign cfg_err   = r_cfg_err;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_perm_box_engine.sv
// -----------------------------------------------------------------------------
// tb_perm_box_engine
//   Directed self-checking bench for perm_box_engine (WIDTH=32, SEL_W=6 so
//   out-of-range config addresses can be driven). Stimulus is applied 1 ns
//   after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_perm_box_engine;

    localparam int WIDTH = 32;
    localparam int SEL_W = 6;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_addr;
    logic [SEL_W-1:0] cfg_data;
    logic             cfg_err;
    logic [CNT_W-1:0] xfer_cnt;
`ifdef PERM_CHECK_EN
    logic             tbl_ok;
`endif

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    perm_box_engine #(
        .WIDTH(WIDTH),
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .xfer_cnt (xfer_cnt)
`ifdef PERM_CHECK_EN
        ,
        .tbl_ok   (tbl_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one edge; caller guarantees in_ready.
    task automatic send(input logic [WIDTH-1:0] d, input logic inv);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got=%0b exp=0", cfg_err); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL rst_xfer_cnt got=%0d exp=0", xfer_cnt); end
`ifdef PERM_CHECK_EN
        checks++; if (tbl_ok !== 1'b1) begin errors++; $display("FAIL rst_tbl_ok got=%0b exp=1", tbl_ok); end
`endif
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_default_fwd();
        out_ready = 1'b0;
        send(32'h0000_8000, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL fwd_data got=%h exp=00000001", out_data); end
        out_ready = 1'b1;
        send(32'h0000_0001, 1'b0);
        checks++; if (out_data !== 32'h0000_0100) begin errors++; $display("FAIL fwd_bit0 got=%h exp=00000100", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_pop got=%0b exp=0", out_valid); end
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL fwd_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_default_inv();
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] f;
        int bad;
        out_ready = 1'b1;
        send(32'h0000_0001, 1'b1);
        checks++; if (out_data !== 32'h0000_8000) begin errors++; $display("FAIL inv_data got=%h exp=00008000", out_data); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            w        = $urandom;
            in_valid = 1'b1;
            in_data  = w;
            in_inv   = 1'b0;
            tick();
            f        = out_data;
            in_data  = f;
            in_inv   = 1'b1;
            tick();
            checks++;
            if (out_data !== w) begin
                errors++;
                if (bad < 5) $display("FAIL roundtrip_%0d got=%h exp=%h", k, out_data, w);
                bad++;
            end
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd200;
        checks++; if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL roundtrip_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp;
        out_ready = 1'b0;
        send(32'h0000_8000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0001;
            in_inv   = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got=%0b exp=0", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0001) begin
                errors++; $display("FAIL bp_hold_%0d got=%0b/%h exp=1/00000001", k, out_valid, out_data); end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = (k % 2 == 1) ? 32'h0000_8000 : 32'h0000_0001;
            exp      = (k % 2 == 1) ? 32'h0000_0001 : 32'h0000_0100;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%0b exp=1", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++; $display("FAIL stream_data_%0d got=%0b/%h exp=1/%h", k, out_valid, out_data, exp); end
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd11;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
        checks++; if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL stream_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_config();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = SEL_W'(i);
            cfg_data = SEL_W'(i);
            if (i == 31) begin
                in_valid = 1'b1;
                in_data  = 32'h0100_0000;
                in_inv   = 1'b0;
            end
            tick();
            in_valid = 1'b0;
        end
        cfg_we = 1'b0;
        // Entry 31 still held DES value 24 when the word was accepted.
        checks++; if (out_data !== 32'h8100_0000) begin errors++; $display("FAIL cfg_old_map got=%h exp=81000000", out_data); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_good got=%0b exp=0", cfg_err); end
        send(32'hDEAD_BEEF, 1'b0);
        checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cfg_ident_fwd got=%h exp=deadbeef", out_data); end
        send(32'hDEAD_BEEF, 1'b1);
        checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cfg_ident_inv got=%h exp=deadbeef", out_data); end
        send(32'h0100_0000, 1'b0);
        checks++; if (out_data !== 32'h0100_0000) begin errors++; $display("FAIL cfg_new_map got=%h exp=01000000", out_data); end
        tick();
        exp_cnt = exp_cnt + 16'd4;

        cfg_we   = 1'b1;
        cfg_addr = 6'd32;
        cfg_data = 6'd5;
        tick();
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_addr got=%0b exp=1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got=%0b exp=0", cfg_err); end
        cfg_we   = 1'b1;
        cfg_addr = 6'd3;
        cfg_data = 6'd40;
        tick();
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_data got=%0b exp=1", cfg_err); end
        send(32'h0000_0008, 1'b0);
        checks++; if (out_data !== 32'h0000_0008) begin errors++; $display("FAIL cfg_unchanged got=%h exp=00000008", out_data); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL cfg_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        send(32'h0000_8000, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got=%0b exp=1", out_valid); end
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b exp=0", out_valid); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", xfer_cnt); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", out_data); end
        tick();
        rst_n   = 1'b1;
        exp_cnt = '0;
        tick();
        send(32'h0000_8000, 1'b0);
        checks++; if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL mid_des_fwd got=%h exp=00000001", out_data); end
        out_ready = 1'b1;
        send(32'h0000_0001, 1'b0);
        checks++; if (out_data !== 32'h0000_0100) begin errors++; $display("FAIL mid_des_bit0 got=%h exp=00000100", out_data); end
        tick();
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL mid_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b0;
    endtask

`ifdef PERM_CHECK_EN
    task automatic test_perm_check();
        out_ready = 1'b1;
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 6'd0; tick();
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 6'd0; tick();
        cfg_we = 1'b0;
        tick();
        checks++; if (tbl_ok !== 1'b0) begin errors++; $display("FAIL chk_tbl_bad got=%0b exp=0", tbl_ok); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL chk_ready_low got=%0b exp=0", in_ready); end
        send(32'h0000_8000, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chk_blocked got=%0b exp=0", out_valid); end
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 6'd15; tick();
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 6'd6;  tick();
        cfg_we = 1'b0;
        tick();
        checks++; if (tbl_ok !== 1'b1) begin errors++; $display("FAIL chk_tbl_good got=%0b exp=1", tbl_ok); end
        send(32'h0000_8000, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0001) begin
            errors++; $display("FAIL chk_resume got=%0b/%h exp=1/00000001", out_valid, out_data); end
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_default_fwd();
        test_default_inv();
        test_back_to_back();
        test_config();
        test_reset_midop();
`ifdef PERM_CHECK_EN
        test_perm_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
